// File: rtl/bcd_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_timer_ctrl
//  Description : Stopwatch-style controller for a four-digit BCD timer.
//                Commands are edge detected. A four-state FSM
//                (IDLE/RUN/PAUSE/LAP) gates a prescaler. Each prescaler
//                tick advances a BCD live count and emits one-cycle
//                per-digit enables. A lap register can freeze the display
//                while the live count keeps advancing.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    PRESCALE  CLK cycles per count tick (legal 2..65535)
//  Ports
//    CLK       in   1   system clock, rising edge
//    Reset     in   1   asynchronous active-low reset
//    Start     in   1   start/resume command (edge detected)
//    Stop      in   1   pause command (edge detected)
//    Clear     in   1   clear-to-idle command (edge detected)
//    Lap       in   1   lap freeze/release toggle (edge detected)
//    En        out  4   per-digit count enables, bit 0 = least significant digit
//    Digits    out  16  displayed value, four BCD nibbles, [3:0] = LSD
//    Running   out  1   high in RUN and LAP
//    Overflow  out  1   sticky 9999->0000 wrap flag
// ============================================================================
module bcd_timer_ctrl #(
    parameter int PRESCALE = 10
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Stop,
    input  logic        Clear,
    input  logic        Lap,
    output logic [3:0]  En,
    output logic [15:0] Digits,
    output logic        Running,
    output logic        Overflow
);

    localparam logic [15:0] PS_MAX = 16'(PRESCALE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_LAP   = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    // Command edge detection. Bit order: {Lap, Start, Stop, Clear}.
    logic [3:0]  cmd_in;
    logic [3:0]  cmd_prev;
    logic        armed;
    logic [3:0]  cmd_edge;

    logic        clear_win;
    logic        stop_win;
    logic        start_win;
    logic        lap_win;

    logic [15:0] presc;
    logic [15:0] count;
    logic [15:0] count_inc;
    logic [15:0] lap_reg;
    logic [3:0]  carry;
    logic        counting;
    logic        tick;
    logic        all_nine;
    logic        en_r;
    logic [3:0]  en_q;
    logic        ovf_q;

    assign cmd_in = {Lap, Start, Stop, Clear};

    // History is zero during reset; the first cycle after release only loads
    // it, so a level already high at release never counts as an edge.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            cmd_prev <= 4'b0000;
            armed    <= 1'b0;
        end else begin
            cmd_prev <= cmd_in;
            armed    <= 1'b1;
        end
    end

    assign cmd_edge = armed ? (cmd_in & ~cmd_prev) : 4'b0000;

    // Priority Clear > Stop > Start > Lap; only the winner is acted on,
    // even if the winner happens to be meaningless in the current state.
    assign clear_win = cmd_edge[0];
    assign stop_win  = cmd_edge[1] & ~cmd_edge[0];
    assign start_win = cmd_edge[2] & ~(|cmd_edge[1:0]);
    assign lap_win   = cmd_edge[3] & ~(|cmd_edge[2:0]);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (clear_win) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_win) state_next = S_RUN;
                end
                S_RUN: begin
                    if (stop_win)     state_next = S_PAUSE;
                    else if (lap_win) state_next = S_LAP;
                end
                S_LAP: begin
                    if (stop_win)     state_next = S_PAUSE;
                    else if (lap_win) state_next = S_RUN;
                end
                S_PAUSE: begin
                    if (start_win) state_next = S_RUN;
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    assign counting = (state == S_RUN) || (state == S_LAP);
    assign tick     = counting && (presc == PS_MAX);

    // ------------------------------------------------------------------
    // BCD increment: digit k advances iff every lower digit is 9. The same
    // carry vector is the enable pattern registered onto En.
    // ------------------------------------------------------------------
    assign carry[0] = 1'b1;

    generate
        for (genvar k = 1; k < 4; k++) begin : g_carry
            assign carry[k] = carry[k-1] & (count[4*(k-1) +: 4] == 4'd9);
        end
        for (genvar k = 0; k < 4; k++) begin : g_digit
            assign count_inc[4*k +: 4] =
                !carry[k]                   ? count[4*k +: 4] :
                (count[4*k +: 4] == 4'd9)   ? 4'd0 :
                                              count[4*k +: 4] + 4'd1;
        end
    endgenerate

    assign all_nine = carry[3] & (count[15:12] == 4'd9);

    // Lap register captures the live count on the RUN->LAP transition.
    assign en_r = (state == S_RUN) && lap_win;

    // ------------------------------------------------------------------
    // Datapath. A tick in the same cycle as a Stop still applies, because
    // the tick depends only on the current state.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            presc   <= 16'd0;
            count   <= 16'h0000;
            lap_reg <= 16'h0000;
            en_q    <= 4'b0000;
            ovf_q   <= 1'b0;
        end else if (clear_win) begin
            presc   <= 16'd0;
            count   <= 16'h0000;
            lap_reg <= 16'h0000;
            en_q    <= 4'b0000;
            ovf_q   <= 1'b0;
        end else begin
            if (counting) begin
                presc <= tick ? 16'd0 : presc + 16'd1;
            end
            if (tick) begin
                count <= count_inc;
                en_q  <= carry;
                if (all_nine) begin
                    ovf_q <= 1'b1;
                end
            end else begin
                en_q <= 4'b0000;
            end
            if (en_r) begin
                lap_reg <= count;
            end
        end
    end

    assign En       = en_q;
    assign Overflow = ovf_q;
    assign Running  = counting;
    assign Digits   = (state == S_LAP) ? lap_reg : count;

endmodule
`default_nettype wire

// File: tb/tb_bcd_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_timer_ctrl
//  Description : Directed self-checking bench for bcd_timer_ctrl, PRESCALE=4.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bcd_timer_ctrl;

    logic        CLK;
    logic        Reset;
    logic        Start;
    logic        Stop;
    logic        Clear;
    logic        Lap;
    logic [3:0]  En;
    logic [15:0] Digits;
    logic        Running;
    logic        Overflow;

    int n_checks;
    int n_fail;

    bcd_timer_ctrl #(.PRESCALE(4)) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .Start    (Start),
        .Stop     (Stop),
        .Clear    (Clear),
        .Lap      (Lap),
        .En       (En),
        .Digits   (Digits),
        .Running  (Running),
        .Overflow (Overflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Run until Digits shows the target (just after its tick edge), bounded.
    task automatic run_to(input string tag, input logic [15:0] target, input int budget);
        int i;
        i = 0;
        while (Digits !== target && i < budget) begin
            step(1);
            i++;
        end
        check(tag, Digits, target);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        Reset = 1'b0; Start = 1'b0; Stop = 1'b0; Clear = 1'b0; Lap = 1'b0;

        // Reset state
        step(3);
        check("rst_digits",   Digits,   16'h0000);
        check("rst_en",       En,       4'b0000);
        check("rst_running",  Running,  1'b0);
        check("rst_overflow", Overflow, 1'b0);
        Reset = 1'b1;
        step(2);

        // Start, ticks every 4th cycle
        Start = 1'b1; step(1); Start = 1'b0;
        check("start_running", Running, 1'b1);
        step(3);
        check("pre_tick_en",     En,     4'b0000);
        check("pre_tick_digits", Digits, 16'h0000);
        step(1);
        check("tick1_en",     En,     4'b0001);
        check("tick1_digits", Digits, 16'h0001);
        step(1);
        check("tick1_en_low", En, 4'b0000);
        step(3);
        check("tick2_en",     En,     4'b0001);
        check("tick2_digits", Digits, 16'h0002);

        // 0099 -> 0100
        run_to("reach_0099", 16'h0099, 500);
        step(4);
        check("c99_digits", Digits, 16'h0100);
        check("c99_en",     En,     4'b0111);
        step(1);
        check("c99_en_low", En, 4'b0000);

        // Stop+Start+Lap together in RUN: PAUSE only, prescaler holds
        Stop = 1'b1; Start = 1'b1; Lap = 1'b1;
        step(1);
        Stop = 1'b0; Start = 1'b0; Lap = 1'b0;
        check("multi_running", Running, 1'b0);
        step(10);
        check("pause_digits", Digits, 16'h0100);
        check("pause_en",     En,     4'b0000);
        Start = 1'b1; step(1); Start = 1'b0;
        check("resume_running", Running, 1'b1);
        step(1);
        check("resume_no_early", Digits, 16'h0100);
        step(1);
        check("resume_tick_digits", Digits, 16'h0101);
        check("resume_tick_en",     En,     4'b0001);

        // Clear, restart, lap freeze/release
        Clear = 1'b1; step(1); Clear = 1'b0;
        check("clr_digits",  Digits,  16'h0000);
        check("clr_running", Running, 1'b0);
        Start = 1'b1; step(1); Start = 1'b0;
        run_to("reach_0005", 16'h0005, 100);
        step(1);
        Lap = 1'b1; step(1); Lap = 1'b0;
        check("lap_running", Running, 1'b1);
        check("lap_digits",  Digits,  16'h0005);
        step(2);
        check("lap_en_pulse",     En,     4'b0001);
        check("lap_frozen_first", Digits, 16'h0005);
        step(8);
        check("lap_frozen_last", Digits, 16'h0005);
        step(1);
        Lap = 1'b1; step(1); Lap = 1'b0;
        check("lap_release_digits", Digits, 16'h0008);

        // Stop coinciding with a tick still applies that tick
        step(1);
        Stop = 1'b1; step(1); Stop = 1'b0;
        check("stop_tick_digits",  Digits,  16'h0009);
        check("stop_tick_en",      En,      4'b0001);
        check("stop_tick_running", Running, 1'b0);

        // 9999 -> 0000 with overflow, then Clear
        Start = 1'b1; step(1); Start = 1'b0;
        run_to("reach_9999", 16'h9999, 41000);
        step(4);
        check("wrap_digits",   Digits,   16'h0000);
        check("wrap_en",       En,       4'b1111);
        check("wrap_overflow", Overflow, 1'b1);
        step(5);
        check("ovf_sticky", Overflow, 1'b1);
        Clear = 1'b1; step(1); Clear = 1'b0;
        check("ovf_clr_overflow", Overflow, 1'b0);
        check("ovf_clr_digits",   Digits,   16'h0000);
        check("ovf_clr_running",  Running,  1'b0);

        // Reset mid-RUN at 0042 with Start held through release
        Start = 1'b1; step(1); Start = 1'b0;
        run_to("reach_0042", 16'h0042, 400);
        step(1);
        Start = 1'b1;
        Reset = 1'b0;
        #2;
        check("async_rst_digits",  Digits,  16'h0000);
        check("async_rst_running", Running, 1'b0);
        step(2);
        Reset = 1'b1;
        step(6);
        check("held_start_running", Running, 1'b0);
        check("held_start_digits",  Digits,  16'h0000);
        Start = 1'b0; step(1);
        Start = 1'b1; step(1); Start = 1'b0;
        check("restart_running", Running, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
